// File: rtl/frame_buffer_pingpong_if.sv
// Pixel-stream bundle between the capture/display side and the frame store.
// Handshake: there is no back-pressure. wr_en marks a write beat and rd_en a
// read request on the cycle they are high. wr_sof/rd_sof only mean something
// together with their enable. rd_valid follows rd_en by exactly one cycle.
// Every *_done/*_drop/*_swap output is a one-cycle pulse.
interface frame_buffer_pingpong_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  wr_en;
    logic                  wr_sof;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic                  rd_sof;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_frame_done;
    logic                  wr_drop;
    logic                  bank_swap;
    logic                  rd_bank;

    modport master (
        output wr_en, wr_sof, data_in, rd_en, rd_sof,
        input  data_out, rd_valid, wr_frame_done, wr_drop, bank_swap, rd_bank
    );

    modport slave (
        input  wr_en, wr_sof, data_in, rd_en, rd_sof,
        output data_out, rd_valid, wr_frame_done, wr_drop, bank_swap, rd_bank
    );
endinterface

// File: rtl/frame_buffer_pingpong.sv
// Single-clock frame store with one or two banks. With two banks the writer
// fills one bank while the reader scans the other. A finished frame is handed
// to the reader only when the reader starts a new frame, which prevents tearing.
module frame_buffer_pingpong #(
    parameter int DATA_WIDTH = 12,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int NUM_BANKS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    frame_buffer_pingpong_if.slave  bus,
    output logic [1:0]              o_wr_state
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = $clog2(NUM_BANKS * DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    generate
        if (NUM_BANKS != 1 && NUM_BANKS != 2) begin : g_bad_banks
            $error("frame_buffer_pingpong: NUM_BANKS must be 1 or 2");
        end
    endgenerate

    // W_IDLE = waiting for sof, W_ACTIVE = filling, W_HOLD = full and waiting for the reader
    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACTIVE = 2'd1,
        W_HOLD   = 2'd2
    } wr_state_t;

    wr_state_t             r_wr_state;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_frame_done;
    logic                  r_drop;
    logic                  r_swap;
    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS*DEPTH];

    logic          w_wr_accept;
    logic [AW-1:0] w_wr_ptr;
    logic          w_wr_last;
    logic          w_swap;
    logic          w_rd_bank;
    logic [AW-1:0] w_rd_ptr;
    logic [MW-1:0] w_wr_addr;
    logic [MW-1:0] w_rd_addr;

    // A beat is stored when it starts a frame from idle or continues/restarts a frame.
    assign w_wr_accept = bus.wr_en &&
                         ((r_wr_state == W_IDLE && bus.wr_sof) || r_wr_state == W_ACTIVE);
    assign w_wr_ptr    = bus.wr_sof ? '0 : r_wr_ptr;
    assign w_wr_last   = w_wr_accept && (w_wr_ptr == LAST_PTR);

    // The swap takes effect on the same cycle for the read address.
    // This means the first pixel of the new frame already comes from the new bank.
    assign w_swap    = (NUM_BANKS == 2) && (r_wr_state == W_HOLD) && bus.rd_en && bus.rd_sof;
    assign w_rd_bank = w_swap ? r_wr_bank : r_rd_bank;
    assign w_rd_ptr  = bus.rd_sof ? '0 : r_rd_ptr;

    // Bank-major layout: bank 1 starts at word DEPTH.
    assign w_wr_addr = (r_wr_bank ? MW'(DEPTH) : MW'(0)) + MW'(w_wr_ptr);
    assign w_rd_addr = (w_rd_bank ? MW'(DEPTH) : MW'(0)) + MW'(w_rd_ptr);

    // Write FSM, write pointer, bank ownership and the write-side pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state   <= W_IDLE;
            r_wr_ptr     <= '0;
            r_wr_bank    <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
            r_swap       <= 1'b0;
        end else begin
            r_frame_done <= w_wr_last;
            r_drop       <= bus.wr_en && !w_wr_accept;
            r_swap       <= w_swap;
            if (w_swap) begin
                r_wr_bank  <= ~r_wr_bank;
                r_wr_state <= W_IDLE;
            end else if (w_wr_accept) begin
                if (w_wr_last) begin
                    r_wr_ptr   <= '0;
                    r_wr_state <= (NUM_BANKS == 2) ? W_HOLD : W_IDLE;
                end else begin
                    r_wr_ptr   <= w_wr_ptr + AW'(1);
                    r_wr_state <= W_ACTIVE;
                end
            end
        end
    end

    // Pixel memory write port. There is no reset, and writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_accept) begin
            r_mem[w_wr_addr] <= bus.data_in;
        end
    end

    // Read port: registered data with one cycle of latency.
    // Non-blocking update order makes a same-word read return the old data (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_rd_bank  <= 1'(NUM_BANKS - 1);
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
            end
            if (bus.rd_en) begin
                r_data_out <= r_mem[w_rd_addr];
                r_rd_ptr   <= (w_rd_ptr == LAST_PTR) ? '0 : w_rd_ptr + AW'(1);
            end
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.wr_frame_done = r_frame_done;
    assign bus.wr_drop       = r_drop;
    assign bus.bank_swap     = r_swap;
    assign bus.rd_bank       = r_rd_bank;
    assign o_wr_state        = r_wr_state;
endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong with a 4x2 frame.
// It builds one ping-pong instance and one single-bank instance, and a
// frame-level reference model predicts every output on every cycle.
module tb_frame_buffer_pingpong;
    localparam int DW    = 12;
    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic [1:0] st2;
    logic [1:0] st1;

    frame_buffer_pingpong_if #(.DATA_WIDTH(DW)) bus2 ();
    frame_buffer_pingpong_if #(.DATA_WIDTH(DW)) bus1 ();

    frame_buffer_pingpong #(.DATA_WIDTH(DW), .H_RES(4), .V_RES(2), .NUM_BANKS(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .o_wr_state(st2)
    );
    frame_buffer_pingpong #(.DATA_WIDTH(DW), .H_RES(4), .V_RES(2), .NUM_BANKS(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .o_wr_state(st1)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model. Phase: 0 = waiting for sof, 1 = filling, 2 = full frame waiting for the reader.
    int m_nb;
    int m_phase, m_wcnt, m_rcnt, m_wbank, m_rbank;
    int m_mem [2][DEPTH];
    bit m_known [2][DEPTH];
    int e_data;
    bit e_known, e_valid, e_drop, e_done, e_swap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus2.wr_en = 0; bus2.wr_sof = 0; bus2.data_in = '0; bus2.rd_en = 0; bus2.rd_sof = 0;
        bus1.wr_en = 0; bus1.wr_sof = 0; bus1.data_in = '0; bus1.rd_en = 0; bus1.rd_sof = 0;
    endtask

    // Reset both instances, check the reset outputs, then re-arm the model for instance nb
    task automatic do_reset(input int nb);
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst2_data_out", 32'(bus2.data_out), 0);
        chk("rst2_flags", {bus2.rd_valid, bus2.wr_frame_done, bus2.wr_drop, bus2.bank_swap}, 0);
        chk("rst2_rd_bank", 32'(bus2.rd_bank), 1);
        chk("rst2_state", 32'(st2), 0);
        chk("rst1_data_out", 32'(bus1.data_out), 0);
        chk("rst1_flags", {bus1.rd_valid, bus1.wr_frame_done, bus1.wr_drop, bus1.bank_swap}, 0);
        chk("rst1_rd_bank", 32'(bus1.rd_bank), 0);
        reset = 1'b0;
        if (nb != m_nb) begin
            for (int b = 0; b < 2; b++) for (int a = 0; a < DEPTH; a++) m_known[b][a] = 0;
        end
        m_nb = nb; m_phase = 0; m_wcnt = 0; m_rcnt = 0; m_wbank = 0; m_rbank = nb - 1;
        e_data = 0; e_known = 1;
    endtask

    // Driver plus model for one cycle on the chosen instance, then compare all outputs
    task automatic step(input int which, input bit we, input bit ws, input int d,
                        input bit re, input bit rs);
        int  rb, rp, wp;
        bit  sw;
        logic [DW-1:0] o_data;
        logic [1:0]    o_st;
        logic          o_valid, o_drop, o_done, o_swap, o_rbank;
        drive_idle();
        if (which == 2) begin
            bus2.wr_en = we; bus2.wr_sof = ws; bus2.data_in = DW'(d); bus2.rd_en = re; bus2.rd_sof = rs;
        end else begin
            bus1.wr_en = we; bus1.wr_sof = ws; bus1.data_in = DW'(d); bus1.rd_en = re; bus1.rd_sof = rs;
        end
        sw = (m_nb == 2) && (m_phase == 2) && re && rs;
        rb = sw ? m_wbank : m_rbank;
        e_valid = re; e_drop = 0; e_done = 0; e_swap = sw;
        if (re) begin
            rp = rs ? 0 : m_rcnt;
            e_known = m_known[rb][rp];
            e_data  = m_mem[rb][rp];
            m_rcnt  = (rp + 1) % DEPTH;
        end
        if (we) begin
            if ((m_phase == 0 && ws) || m_phase == 1) begin
                wp = ws ? 0 : m_wcnt;
                m_mem[m_wbank][wp] = d;
                m_known[m_wbank][wp] = 1;
                if (wp == DEPTH - 1) begin
                    e_done = 1; m_wcnt = 0; m_phase = (m_nb == 2) ? 2 : 0;
                end else begin
                    m_wcnt = wp + 1; m_phase = 1;
                end
            end else begin
                e_drop = 1;
            end
        end
        if (sw) begin
            m_rbank = m_wbank; m_wbank = 1 - m_wbank; m_phase = 0;
        end
        @(posedge clk); #1;
        if (which == 2) begin
            o_data = bus2.data_out; o_valid = bus2.rd_valid; o_drop = bus2.wr_drop;
            o_done = bus2.wr_frame_done; o_swap = bus2.bank_swap; o_rbank = bus2.rd_bank; o_st = st2;
        end else begin
            o_data = bus1.data_out; o_valid = bus1.rd_valid; o_drop = bus1.wr_drop;
            o_done = bus1.wr_frame_done; o_swap = bus1.bank_swap; o_rbank = bus1.rd_bank; o_st = st1;
        end
        chk("rd_valid", 32'(o_valid), 32'(e_valid));
        chk("wr_drop", 32'(o_drop), 32'(e_drop));
        chk("wr_frame_done", 32'(o_done), 32'(e_done));
        chk("bank_swap", 32'(o_swap), 32'(e_swap));
        chk("rd_bank", 32'(o_rbank), 32'(m_rbank));
        chk("wr_state", 32'(o_st), 32'(m_phase));
        if (e_known) chk("data_out", 32'(o_data), 32'(e_data));
    endtask

    task automatic write_frame(input int which, input bit counting);
        for (int i = 0; i < DEPTH; i++)
            step(which, 1, i == 0, counting ? i + 1 : int'($urandom_range(0, 4095)), 0, 0);
    endtask

    task automatic read_frame(input int which);
        for (int i = 0; i < DEPTH; i++) step(which, 0, 0, 0, 1, i == 0);
    endtask

    task automatic random_cycles(input int which, input int n);
        for (int i = 0; i < n; i++)
            step(which, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 4095)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0);
    endtask

    initial begin
        m_nb = 0;
        do_reset(2);

        // frame 1..8 goes to bank 0, and the writer then holds
        write_frame(2, 1);
        chk("t1_hold", 32'(st2), 2);

        // reader start swaps to bank 0 and streams 1..8
        read_frame(2);
        chk("t2_rd_bank", 32'(bus2.rd_bank), 0);
        chk("t2_last_pixel", 32'(bus2.data_out), 8);

        // fill bank 1, then beats arriving in hold are dropped
        write_frame(2, 0);
        for (int i = 0; i < 3; i++) step(2, 1, 0, int'($urandom_range(0, 4095)), 0, 0);
        read_frame(2);

        // restart at beat 5, and only the second frame completes
        for (int i = 0; i < 5; i++) step(2, 1, i == 0, int'($urandom_range(0, 4095)), 0, 0);
        write_frame(2, 0);
        read_frame(2);

        random_cycles(2, 300);

        // reset during an active frame, then during hold
        do_reset(2);
        for (int i = 0; i < 3; i++) step(2, 1, i == 0, int'($urandom_range(0, 4095)), 0, 0);
        do_reset(2);
        step(2, 1, 0, 5, 0, 0);
        write_frame(2, 0);
        do_reset(2);
        step(2, 1, 0, 5, 0, 0);
        write_frame(2, 0);
        read_frame(2);

        // single bank: read-first collision at address 3, then pointer wrap
        do_reset(1);
        write_frame(1, 1);
        step(1, 1, 1, 100, 1, 1);
        step(1, 1, 0, 101, 1, 0);
        step(1, 1, 0, 102, 1, 0);
        step(1, 1, 0, 103, 1, 0);
        chk("t5_read_first", 32'(bus1.data_out), 4);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("t5_wrap", 32'(bus1.data_out), 100);
        random_cycles(1, 300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
